// File: rtl/timer_device_if.sv
// Peripheral-bus port bundle for one timer slot. The bridge (master) drives
// the decoded address, write strobe and write data; the timer (slave) returns
// combinational read data and its interrupt request.
interface timer_device_if;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   modport master (output Addr, output WE, output Din, input Dout, input IRQ);
   modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_device.sv
// Programmable 32-bit down-counting timer with one-shot and auto-reload
// modes and a maskable interrupt request. Registers: CTRL, PRESET, COUNT.
module timer_device (
   input  logic           clk,
   input  logic           reset,
   timer_device_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   state_t      state, state_nxt;
   logic [3:0]  ctrl;          // {IM, Mode[1:0], Enable}
   logic [31:0] preset;
   logic [31:0] count, count_nxt;
   logic        irq_flag, irq_flag_nxt;
   logic        clr_enable;    // one-shot completion drops Enable

   logic [1:0]  sel;
   logic        ctrl_en;
   logic        auto_reload;
   logic        wr_ctrl;
   logic        wr_preset;

   // Only Addr[3:2] selects a register; the bridge has already matched the slot.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^bus.Addr[31:4];

   assign sel         = bus.Addr[3:2];
   assign ctrl_en     = ctrl[0];
   assign auto_reload = (ctrl[2:1] == 2'b01);
   assign wr_ctrl     = bus.WE && (sel == REG_CTRL);
   assign wr_preset   = bus.WE && (sel == REG_PRESET);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always blocks are evaluated in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state, next-count and interrupt-flag decisions.
   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      irq_flag_nxt = irq_flag;
      clr_enable   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (ctrl_en) begin
               state_nxt    = S_LOAD;
               irq_flag_nxt = 1'b0;
            end
         end
         S_LOAD: begin
            count_nxt = preset;
            state_nxt = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_en) begin
               state_nxt = S_IDLE;
            end else if (count > 32'd1) begin
               count_nxt = count - 32'd1;
            end else begin
               // A preset of 0 lands here too and behaves like a preset of 1.
               count_nxt    = 32'd0;
               irq_flag_nxt = 1'b1;
               state_nxt    = S_INT;
            end
         end
         S_INT: begin
            if (auto_reload) irq_flag_nxt = 1'b0;
            else             clr_enable   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // CTRL register: a CPU write wins over the one-shot Enable clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl <= 4'd0;
      end else if (wr_ctrl) begin
         ctrl <= bus.Din[3:0];
      end else if (clr_enable) begin
         ctrl[0] <= 1'b0;
      end
   end

   // PRESET register: only sampled in LOAD, so a write never disturbs a running count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          preset <= 32'd0;
      else if (wr_preset) preset <= bus.Din;
   end

   // COUNT and interrupt flag follow the FSM decisions; COUNT is not CPU-writable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         count    <= count_nxt;
         irq_flag <= irq_flag_nxt;
      end
   end

   // Zero-wait-state read mux.
   always_comb begin
      bus.Dout = 32'd0;
      unique case (sel)
         REG_CTRL:   bus.Dout = {28'd0, ctrl};
         REG_PRESET: bus.Dout = preset;
         REG_COUNT:  bus.Dout = count;
         default:    bus.Dout = 32'd0;
      endcase
   end

   assign bus.IRQ = ctrl[3] & irq_flag;

endmodule
